dmem_ctrl: RTL

- Parametrised data-memory controller for the Minisys CPU.
- Holds 2**ADDR_W 32-bit words with byte-lane write enables.
- Supports byte, halfword and word loads and stores, with sign or zero extension and misalignment detection.
- Provides a registered 1-cycle read and an on-reset zeroing sweep; the UART-programmer (UPG) write path owns the memory until programming completes.

---
 rtl/dmem_ctrl.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller for the Minisys CPU.
// Holds 2**ADDR_W 32-bit words as four byte lanes. Supports byte, half and
// word loads and stores with sign/zero extension and misalignment detection.
// After reset the memory can be zeroed (CLEAR), is then owned by the UART
// programmer (PROG), and is handed to the CPU (RUN) once programming is done.
// Optional feature macro: DMEM_ACCESS_CNT_EN adds load_cnt/store_cnt outputs.
module dmem_ctrl #(
    parameter int ADDR_W         = 14,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    input  logic [31:0]       address,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              read_valid,
    output logic              misaligned,
    output logic              ready,
    input  logic              upg_wen_i,
    input  logic [ADDR_W-1:0] upg_adr_i,
    input  logic [31:0]       upg_dat_i,
    input  logic              upg_done_i
`ifdef DMEM_ACCESS_CNT_EN
    ,
    output logic [31:0]       load_cnt,
    output logic [31:0]       store_cnt
`endif
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_PROG  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic              read_valid_q, read_valid_d;
    logic              misaligned_q, misaligned_d;
    logic              ready_q, ready_d;
    logic [1:0]        ld_size_q, ld_size_d;
    logic [1:0]        ld_off_q, ld_off_d;
    logic              ld_unsigned_q, ld_unsigned_d;

    // Request decode
    logic [ADDR_W-1:0] cpu_word_adr;
    logic              is_run;
    logic              req_misal;
    logic              st_ok;
    logic              ld_ok;
    logic              unused_addr_bits;

    assign cpu_word_adr     = address[ADDR_W+1:2];
    assign unused_addr_bits = ^address[31:ADDR_W+2];
    assign is_run           = (state_q == ST_RUN);

    // Alignment check: half needs bit 0 clear, word (and size 11) needs bits 1:0 clear
    always_comb begin
        req_misal = 1'b0;
        case (size)
            2'b00:   req_misal = 1'b0;
            2'b01:   req_misal = address[0];
            default: req_misal = |address[1:0];
        endcase
    end

    assign st_ok = is_run & mem_write & ~req_misal;
    assign ld_ok = is_run & mem_read & ~mem_write & ~req_misal;

    // Memory write port: the owner depends on the controller state
    logic              wr_en;
    logic [ADDR_W-1:0] wr_adr;
    logic [3:0]        wr_be;
    logic [31:0]       wr_data;

    // Select write source (sweep, programmer or CPU store) and lane enables
    always_comb begin
        wr_en   = 1'b0;
        wr_adr  = cpu_word_adr;
        wr_be   = 4'b0000;
        wr_data = 32'h0;
        case (state_q)
            ST_CLEAR: begin
                wr_en   = 1'b1;
                wr_adr  = clr_ptr_q;
                wr_be   = 4'b1111;
                wr_data = 32'h0;
            end
            ST_PROG: begin
                wr_en   = upg_wen_i;
                wr_adr  = upg_adr_i;
                wr_be   = 4'b1111;
                wr_data = upg_dat_i;
            end
            ST_RUN: begin
                wr_en  = st_ok;
                wr_adr = cpu_word_adr;
                case (size)
                    2'b00: begin
                        wr_be   = 4'b0001 << address[1:0];
                        wr_data = {4{write_data[7:0]}};
                    end
                    2'b01: begin
                        wr_be   = address[1] ? 4'b1100 : 4'b0011;
                        wr_data = {2{write_data[15:0]}};
                    end
                    default: begin
                        wr_be   = 4'b1111;
                        wr_data = write_data;
                    end
                endcase
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    // Byte-lane block RAMs with registered read
    logic [31:0] rd_word;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_rd_q;

            // Lane write (blocked during reset so reset never corrupts memory) and registered read
            always_ff @(posedge clock) begin
                if (wr_en && wr_be[gi] && !reset) begin
                    lane_mem[wr_adr] <= wr_data[8*gi +: 8];
                end
                lane_rd_q <= lane_mem[cpu_word_adr];
            end

            assign rd_word[8*gi +: 8] = lane_rd_q;
        end
    endgenerate

    // Next-state logic for the FSM, sweep pointer and load response pipeline
    always_comb begin
        state_d       = state_q;
        clr_ptr_d     = clr_ptr_q;
        case (state_q)
            ST_CLEAR: begin
                clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_PROG;
                end
            end
            ST_PROG: begin
                if (upg_done_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_PROG;
        endcase
        read_valid_d  = ld_ok;
        misaligned_d  = is_run & (mem_read | mem_write) & req_misal;
        ready_d       = (state_d == ST_RUN);
        ld_size_d     = size;
        ld_off_d      = address[1:0];
        ld_unsigned_d = unsigned_ld;
    end

    // FSM and registered response state
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= CLEAR_ON_RESET ? ST_CLEAR : ST_PROG;
            clr_ptr_q     <= '0;
            read_valid_q  <= 1'b0;
            misaligned_q  <= 1'b0;
            ready_q       <= 1'b0;
            ld_size_q     <= 2'b00;
            ld_off_q      <= 2'b00;
            ld_unsigned_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_ptr_q     <= clr_ptr_d;
            read_valid_q  <= read_valid_d;
            misaligned_q  <= misaligned_d;
            ready_q       <= ready_d;
            ld_size_q     <= ld_size_d;
            ld_off_q      <= ld_off_d;
            ld_unsigned_q <= ld_unsigned_d;
        end
    end

    // Lane extraction and extension on the registered RAM word
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    always_comb begin
        case (ld_off_q)
            2'b00:   ld_byte = rd_word[7:0];
            2'b01:   ld_byte = rd_word[15:8];
            2'b10:   ld_byte = rd_word[23:16];
            default: ld_byte = rd_word[31:24];
        endcase
        ld_half = ld_off_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (ld_size_q)
            2'b00:   ld_ext = {{24{ld_byte[7] & ~ld_unsigned_q}}, ld_byte};
            2'b01:   ld_ext = {{16{ld_half[15] & ~ld_unsigned_q}}, ld_half};
            default: ld_ext = rd_word;
        endcase
    end

    // read_data is forced to zero whenever no valid load result is presented
    assign read_data  = read_valid_q ? ld_ext : 32'h0;
    assign read_valid = read_valid_q;
    assign misaligned = misaligned_q;
    assign ready      = ready_q;

`ifdef DMEM_ACCESS_CNT_EN
    logic [31:0] load_cnt_q, load_cnt_d;
    logic [31:0] store_cnt_q, store_cnt_d;

    // Count accepted aligned loads and stores; both wrap naturally
    always_comb begin
        load_cnt_d  = load_cnt_q + (ld_ok ? 32'd1 : 32'd0);
        store_cnt_d = store_cnt_q + (st_ok ? 32'd1 : 32'd0);
    end

    // Access counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            load_cnt_q  <= 32'h0;
            store_cnt_q <= 32'h0;
        end else begin
            load_cnt_q  <= load_cnt_d;
            store_cnt_q <= store_cnt_d;
        end
    end

    assign load_cnt  = load_cnt_q;
    assign store_cnt = store_cnt_q;
`endif

endmodule
